// File: rtl/fetch_pkg.sv
// -----------------------------------------------------------------------------
// fetch_pkg
// Shared core definitions for the instruction fetch unit:
//   XLEN          - datapath width (32)
//   NOP_INSTR     - canonical NOP (addi x0,x0,0) placed in a squashed IF/ID
//   fetch_state_e - fetch control FSM states
//   pc_plus4()    - sequential PC increment, wraps modulo 2^32
// -----------------------------------------------------------------------------
package fetch_pkg;

   localparam int XLEN = 32;

   localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      REQ     = 3'd1,
      WAIT    = 3'd2,
      HOLD    = 3'd3,
      DISCARD = 3'd4
   } fetch_state_e;

   // Natural overflow of the 32-bit add gives the modulo-2^32 wrap.
   function automatic logic [XLEN-1:0] pc_plus4(input logic [XLEN-1:0] pc);
      return pc + 32'd4;
   endfunction

endpackage

// File: rtl/fetch_hold_buf.sv
// -----------------------------------------------------------------------------
// fetch_hold_buf
// One-entry buffer that parks a fetched instruction (and its pc) while the
// IF/ID register is stalled.
// Ports:
//   clk_i, rst_i        - clock, asynchronous active-high reset
//   capture_i           - load pc_i/instr_i and mark the entry valid
//   clear_i             - invalidate the entry (wins over capture_i)
//   pc_i, instr_i       - data to capture
//   valid_o, pc_o,
//   instr_o             - current buffer contents
// -----------------------------------------------------------------------------
module fetch_hold_buf
   import fetch_pkg::*;
(
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic            capture_i,
   input  logic            clear_i,
   input  logic [XLEN-1:0] pc_i,
   input  logic [XLEN-1:0] instr_i,
   output logic            valid_o,
   output logic [XLEN-1:0] pc_o,
   output logic [XLEN-1:0] instr_o
);

   logic            valid_q, valid_d;
   logic [XLEN-1:0] pc_q, pc_d;
   logic [XLEN-1:0] instr_q, instr_d;

   // Next-state for the buffer entry.
   always_comb begin
      valid_d = valid_q;
      pc_d    = pc_q;
      instr_d = instr_q;
      if (clear_i) begin
         valid_d = 1'b0;
      end else if (capture_i) begin
         valid_d = 1'b1;
         pc_d    = pc_i;
         instr_d = instr_i;
      end else begin
         valid_d = valid_q;
      end
   end

   // Buffer storage.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         valid_q <= 1'b0;
         pc_q    <= 32'h0000_0000;
         instr_q <= NOP_INSTR;
      end else begin
         valid_q <= valid_d;
         pc_q    <= pc_d;
         instr_q <= instr_d;
      end
   end

   assign valid_o = valid_q;
   assign pc_o    = pc_q;
   assign instr_o = instr_q;

endmodule

// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
// Instruction fetch stage: pc register, single-outstanding-request memory
// handshake FSM, stall hold buffer and the IF/ID pipeline register.
// Parameters:
//   RESET_PC        - first fetch address after reset
// Ports:
//   clk_i, rst_i    - clock, asynchronous active-high reset
//   redirect_i,
//   target_addr_i   - change of flow from EX (highest priority pc source)
//   flush_i         - squash IF/ID to a NOP bubble
//   stall_i         - hold IF/ID
//   imem_req_o,
//   imem_addr_o     - fetch request / address
//   imem_gnt_i      - request accepted
//   imem_rvalid_i,
//   imem_rdata_i    - response valid / instruction word
//   if_id_*_o       - IF/ID register (valid, pc, pc+4, instr)
// Build option:
//   FETCH_MISALIGN_CHECK_EN - adds misaligned_o; redirect targets are forced
//                             to word alignment and a misaligned target
//                             raises a one-cycle pulse.
// -----------------------------------------------------------------------------
module fetch_unit
   import fetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        redirect_i,
   input  logic [31:0] target_addr_i,
   input  logic        flush_i,
   input  logic        stall_i,
   output logic        imem_req_o,
   output logic [31:0] imem_addr_o,
   input  logic        imem_gnt_i,
   input  logic        imem_rvalid_i,
   input  logic [31:0] imem_rdata_i,
   output logic        if_id_valid_o,
   output logic [31:0] if_id_pc_o,
   output logic [31:0] if_id_pc4_o,
   output logic [31:0] if_id_instr_o
`ifdef FETCH_MISALIGN_CHECK_EN
   ,
   output logic        misaligned_o
`endif
);

   fetch_state_e    state_q, state_d;
   logic [XLEN-1:0] pc_q, pc_d;

   logic            if_id_valid_q, if_id_valid_d;
   logic [XLEN-1:0] if_id_pc_q, if_id_pc_d;
   logic [XLEN-1:0] if_id_pc4_q, if_id_pc4_d;
   logic [XLEN-1:0] if_id_instr_q, if_id_instr_d;

   logic [XLEN-1:0] redir_pc_s;
   logic            load_s;
   logic [XLEN-1:0] load_pc_s;
   logic [XLEN-1:0] load_instr_s;
   logic            buf_capture_s;
   logic            buf_clear_s;
   logic            buf_valid_s;
   logic [XLEN-1:0] buf_pc_s;
   logic [XLEN-1:0] buf_instr_s;

`ifdef FETCH_MISALIGN_CHECK_EN
   logic misaligned_q, misaligned_d;

   // Word-align redirect targets and flag misaligned ones.
   always_comb begin
      redir_pc_s   = {target_addr_i[31:2], 2'b00};
      misaligned_d = redirect_i & (target_addr_i[1:0] != 2'b00);
   end

   // Misalignment pulse register.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         misaligned_q <= 1'b0;
      end else begin
         misaligned_q <= misaligned_d;
      end
   end

   assign misaligned_o = misaligned_q;
`else
   assign redir_pc_s = target_addr_i;
`endif

   // Fetch FSM next-state, pc update and IF/ID load requests.
   always_comb begin
      state_d       = state_q;
      pc_d          = pc_q;
      load_s        = 1'b0;
      load_pc_s     = pc_q;
      load_instr_s  = imem_rdata_i;
      buf_capture_s = 1'b0;
      buf_clear_s   = 1'b0;
      case (state_q)
         IDLE: begin
            state_d = REQ;
            if (redirect_i) begin
               pc_d = redir_pc_s;
            end else begin
               pc_d = pc_q;
            end
         end
         REQ: begin
            if (redirect_i) begin
               pc_d = redir_pc_s;
               // A granted request already targets the stale pc; its
               // response must be thrown away.
               if (imem_gnt_i) begin
                  state_d = DISCARD;
               end else begin
                  state_d = REQ;
               end
            end else if (imem_gnt_i) begin
               state_d = WAIT;
            end else begin
               state_d = REQ;
            end
         end
         WAIT: begin
            if (redirect_i) begin
               pc_d = redir_pc_s;
               if (imem_rvalid_i) begin
                  state_d = REQ;
               end else begin
                  state_d = DISCARD;
               end
            end else if (imem_rvalid_i) begin
               if (stall_i) begin
                  buf_capture_s = 1'b1;
                  state_d       = HOLD;
               end else begin
                  load_s  = 1'b1;
                  pc_d    = pc_plus4(pc_q);
                  state_d = REQ;
               end
            end else begin
               state_d = WAIT;
            end
         end
         HOLD: begin
            if (redirect_i) begin
               pc_d        = redir_pc_s;
               buf_clear_s = 1'b1;
               state_d     = REQ;
            end else if (!stall_i) begin
               load_s       = buf_valid_s;
               load_pc_s    = buf_pc_s;
               load_instr_s = buf_instr_s;
               pc_d         = pc_plus4(buf_pc_s);
               buf_clear_s  = 1'b1;
               state_d      = REQ;
            end else begin
               state_d = HOLD;
            end
         end
         DISCARD: begin
            if (redirect_i) begin
               pc_d = redir_pc_s;
            end else begin
               pc_d = pc_q;
            end
            if (imem_rvalid_i) begin
               state_d = REQ;
            end else begin
               state_d = DISCARD;
            end
         end
         default: begin
            state_d = IDLE;
            pc_d    = RESET_PC;
         end
      endcase
   end

   // IF/ID next value: flush beats stall beats load. With no stall and
   // nothing to load the slot becomes a bubble so ID never sees the same
   // instruction twice.
   always_comb begin
      if_id_valid_d = if_id_valid_q;
      if_id_pc_d    = if_id_pc_q;
      if_id_pc4_d   = if_id_pc4_q;
      if_id_instr_d = if_id_instr_q;
      if (flush_i) begin
         if_id_valid_d = 1'b0;
         if_id_instr_d = NOP_INSTR;
      end else if (stall_i) begin
         if_id_valid_d = if_id_valid_q;
      end else if (load_s) begin
         if_id_valid_d = 1'b1;
         if_id_pc_d    = load_pc_s;
         if_id_pc4_d   = pc_plus4(load_pc_s);
         if_id_instr_d = load_instr_s;
      end else begin
         if_id_valid_d = 1'b0;
      end
   end

   // FSM, pc and IF/ID registers.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q       <= IDLE;
         pc_q          <= RESET_PC;
         if_id_valid_q <= 1'b0;
         if_id_pc_q    <= 32'h0000_0000;
         if_id_pc4_q   <= 32'h0000_0000;
         if_id_instr_q <= NOP_INSTR;
      end else begin
         state_q       <= state_d;
         pc_q          <= pc_d;
         if_id_valid_q <= if_id_valid_d;
         if_id_pc_q    <= if_id_pc_d;
         if_id_pc4_q   <= if_id_pc4_d;
         if_id_instr_q <= if_id_instr_d;
      end
   end

   fetch_hold_buf u_hold_buf (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .capture_i (buf_capture_s),
      .clear_i   (buf_clear_s),
      .pc_i      (pc_q),
      .instr_i   (imem_rdata_i),
      .valid_o   (buf_valid_s),
      .pc_o      (buf_pc_s),
      .instr_o   (buf_instr_s)
   );

   // Request is a pure decode of the state flop; the address is the pc flop.
   assign imem_req_o    = (state_q == REQ);
   assign imem_addr_o   = pc_q;
   assign if_id_valid_o = if_id_valid_q;
   assign if_id_pc_o    = if_id_pc_q;
   assign if_id_pc4_o   = if_id_pc4_q;
   assign if_id_instr_o = if_id_instr_q;

endmodule

// File: tb/tb_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_fetch_unit
// Table-driven bench for fetch_unit. A second instance with
// RESET_PC = 32'hFFFF_FFFC runs with grant and rvalid tied high to show the
// pc wrap on its second request.
// -----------------------------------------------------------------------------
module tb_fetch_unit;

   localparam logic [31:0] NOP = 32'h0000_0013;

   logic        clk = 1'b0;
   logic        rst;
   logic        redirect;
   logic [31:0] target;
   logic        flush;
   logic        stall;
   logic        gnt;
   logic        rvalid;
   logic [31:0] rdata;
   logic        req;
   logic [31:0] addr;
   logic        v;
   logic [31:0] pc;
   logic [31:0] pc4;
   logic [31:0] instr;

   logic        w_redirect = 1'b0;
   logic [31:0] w_target   = 32'h0000_0000;
   logic        w_flush    = 1'b0;
   logic        w_stall    = 1'b0;
   logic        w_gnt      = 1'b1;
   logic        w_rvalid   = 1'b1;
   logic [31:0] w_rdata    = 32'h0000_0013;
   logic        w_req;
   logic [31:0] w_addr;
   logic        w_v;
   logic [31:0] w_pc;
   logic [31:0] w_pc4;
   logic [31:0] w_instr;

`ifdef FETCH_MISALIGN_CHECK_EN
   logic        mis;
   logic        w_mis;
`endif

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
      .clk_i(clk), .rst_i(rst), .redirect_i(redirect), .target_addr_i(target),
      .flush_i(flush), .stall_i(stall), .imem_req_o(req), .imem_addr_o(addr),
      .imem_gnt_i(gnt), .imem_rvalid_i(rvalid), .imem_rdata_i(rdata),
      .if_id_valid_o(v), .if_id_pc_o(pc), .if_id_pc4_o(pc4), .if_id_instr_o(instr)
`ifdef FETCH_MISALIGN_CHECK_EN
      , .misaligned_o(mis)
`endif
   );

   fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
      .clk_i(clk), .rst_i(rst), .redirect_i(w_redirect), .target_addr_i(w_target),
      .flush_i(w_flush), .stall_i(w_stall), .imem_req_o(w_req), .imem_addr_o(w_addr),
      .imem_gnt_i(w_gnt), .imem_rvalid_i(w_rvalid), .imem_rdata_i(w_rdata),
      .if_id_valid_o(w_v), .if_id_pc_o(w_pc), .if_id_pc4_o(w_pc4), .if_id_instr_o(w_instr)
`ifdef FETCH_MISALIGN_CHECK_EN
      , .misaligned_o(w_mis)
`endif
   );

   typedef struct {
      logic        redirect;
      logic [31:0] target;
      logic        flush;
      logic        stall;
      logic        gnt;
      logic        rvalid;
      logic [31:0] rdata;
      logic        exp_req;
      logic [31:0] exp_addr;
      logic        exp_valid;
      logic [31:0] exp_pc;
      logic [31:0] exp_pc4;
      logic [31:0] exp_instr;
   } vec_t;

   vec_t vq[$];

   function automatic vec_t mk(
      input logic r, input logic [31:0] t, input logic f, input logic s,
      input logic g, input logic rv, input logic [31:0] d,
      input logic e_req, input logic [31:0] e_addr, input logic e_v,
      input logic [31:0] e_pc, input logic [31:0] e_pc4, input logic [31:0] e_in);
      vec_t x;
      x = '{r, t, f, s, g, rv, d, e_req, e_addr, e_v, e_pc, e_pc4, e_in};
      return x;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic check_ifid(input string tag, input logic e_req, input logic [31:0] e_addr,
                             input logic e_v, input logic [31:0] e_pc,
                             input logic [31:0] e_pc4, input logic [31:0] e_in);
      check({tag, " req"},   {31'd0, req}, {31'd0, e_req});
      check({tag, " addr"},  addr,  e_addr);
      check({tag, " valid"}, {31'd0, v}, {31'd0, e_v});
      check({tag, " pc"},    pc,    e_pc);
      check({tag, " pc4"},   pc4,   e_pc4);
      check({tag, " instr"}, instr, e_in);
   endtask

   initial begin
      // redir target flush stall gnt rvalid rdata | req addr valid pc pc4 instr
      vq.push_back(mk(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,          1'b1, 32'h0,   1'b0, 32'h0,   32'h0,   NOP));
      vq.push_back(mk(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0,          1'b0, 32'h0,   1'b0, 32'h0,   32'h0,   NOP));
      vq.push_back(mk(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h1111_0001,  1'b1, 32'h4,   1'b1, 32'h0,   32'h4,   32'h1111_0001));
      vq.push_back(mk(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0,          1'b0, 32'h4,   1'b0, 32'h0,   32'h4,   32'h1111_0001));
      vq.push_back(mk(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h2222_0002,  1'b1, 32'h8,   1'b1, 32'h4,   32'h8,   32'h2222_0002));
      // redirect to 0x100 together with the grant for 0x8
      vq.push_back(mk(1'b1, 32'h100, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0,        1'b0, 32'h100, 1'b0, 32'h4,   32'h8,   32'h2222_0002));
      vq.push_back(mk(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h3333_0003,  1'b1, 32'h100, 1'b0, 32'h4,   32'h8,   32'h2222_0002));
      vq.push_back(mk(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0,          1'b0, 32'h100, 1'b0, 32'h4,   32'h8,   32'h2222_0002));
      vq.push_back(mk(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h4444_0004,  1'b1, 32'h104, 1'b1, 32'h100, 32'h104, 32'h4444_0004));
      // redirect in REQ without grant, then a stall spanning the response
      vq.push_back(mk(1'b1, 32'h10, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0,         1'b1, 32'h10,  1'b1, 32'h100, 32'h104, 32'h4444_0004));
      vq.push_back(mk(1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0,          1'b0, 32'h10,  1'b1, 32'h100, 32'h104, 32'h4444_0004));
      vq.push_back(mk(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b1, 32'hDEAD_BEEF,  1'b0, 32'h10,  1'b1, 32'h100, 32'h104, 32'h4444_0004));
      vq.push_back(mk(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0,          1'b0, 32'h10,  1'b1, 32'h100, 32'h104, 32'h4444_0004));
      vq.push_back(mk(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,          1'b1, 32'h14,  1'b1, 32'h10,  32'h14,  32'hDEAD_BEEF));
      // flush with stall, then flush colliding with a load
      vq.push_back(mk(1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0,          1'b1, 32'h14,  1'b0, 32'h10,  32'h14,  NOP));
      vq.push_back(mk(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0,          1'b0, 32'h14,  1'b0, 32'h10,  32'h14,  NOP));
      vq.push_back(mk(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b1, 32'h5555_0005,  1'b1, 32'h18,  1'b0, 32'h10,  32'h14,  NOP));
      // redirect in WAIT with rvalid -> straight to REQ
      vq.push_back(mk(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0,          1'b0, 32'h18,  1'b0, 32'h10,  32'h14,  NOP));
      vq.push_back(mk(1'b1, 32'h200, 1'b0, 1'b0, 1'b0, 1'b1, 32'h6666_0006, 1'b1, 32'h200, 1'b0, 32'h10, 32'h14,  NOP));
      // redirect in WAIT without rvalid -> DISCARD
      vq.push_back(mk(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0,          1'b0, 32'h200, 1'b0, 32'h10,  32'h14,  NOP));
      vq.push_back(mk(1'b1, 32'h300, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 32'h300, 1'b0, 32'h10,  32'h14,  NOP));
      vq.push_back(mk(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h7777_0007,  1'b1, 32'h300, 1'b0, 32'h10,  32'h14,  NOP));
      vq.push_back(mk(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0,          1'b0, 32'h300, 1'b0, 32'h10,  32'h14,  NOP));
      vq.push_back(mk(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h8888_0008,  1'b1, 32'h304, 1'b1, 32'h300, 32'h304, 32'h8888_0008));
      // redirect while holding a buffered response drops the buffer
      vq.push_back(mk(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0,          1'b0, 32'h304, 1'b0, 32'h300, 32'h304, 32'h8888_0008));
      vq.push_back(mk(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b1, 32'h9999_0009,  1'b0, 32'h304, 1'b0, 32'h300, 32'h304, 32'h8888_0008));
      vq.push_back(mk(1'b1, 32'h400, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0,        1'b1, 32'h400, 1'b0, 32'h300, 32'h304, 32'h8888_0008));
      vq.push_back(mk(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,          1'b1, 32'h400, 1'b0, 32'h300, 32'h304, 32'h8888_0008));
      // pc+4 wrap through IF/ID
      vq.push_back(mk(1'b1, 32'hFFFF_FFFC, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,  1'b1, 32'hFFFF_FFFC, 1'b0, 32'h300, 32'h304, 32'h8888_0008));
      vq.push_back(mk(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0,          1'b0, 32'hFFFF_FFFC, 1'b0, 32'h300, 32'h304, 32'h8888_0008));
      vq.push_back(mk(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 32'hAAAA_000A,  1'b1, 32'h0,   1'b1, 32'hFFFF_FFFC, 32'h0, 32'hAAAA_000A));

      rst = 1'b1; redirect = 1'b0; target = 32'h0; flush = 1'b0; stall = 1'b0;
      gnt = 1'b0; rvalid = 1'b0; rdata = 32'h0;
      repeat (2) @(posedge clk);
      #1;
      check_ifid("reset", 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, NOP);
      check("reset wrap addr", w_addr, 32'hFFFF_FFFC);
`ifdef FETCH_MISALIGN_CHECK_EN
      check("reset misaligned", {31'd0, mis}, 32'h0);
`endif
      rst = 1'b0;

      for (int i = 0; i < vq.size(); i++) begin
         logic [31:0] e_waddr;
         redirect = vq[i].redirect; target = vq[i].target; flush = vq[i].flush;
         stall = vq[i].stall; gnt = vq[i].gnt; rvalid = vq[i].rvalid; rdata = vq[i].rdata;
         @(posedge clk);
         #1;
         check_ifid($sformatf("row%0d", i), vq[i].exp_req, vq[i].exp_addr, vq[i].exp_valid,
                    vq[i].exp_pc, vq[i].exp_pc4, vq[i].exp_instr);
         // wrap instance: REQ/WAIT alternate, pc steps by 4 every two cycles
         if (i < 6) begin
            e_waddr = 32'hFFFF_FFFC + 32'(4 * (i / 2));
            check($sformatf("row%0d wrap addr", i), w_addr, e_waddr);
            check($sformatf("row%0d wrap req", i), {31'd0, w_req}, {31'd0, ((i % 2) == 0)});
         end
      end

      // Reset while a request is outstanding; stale responses must be ignored.
      redirect = 1'b0; flush = 1'b0; stall = 1'b0; gnt = 1'b1; rvalid = 1'b0;
      @(posedge clk);
      #1;
      check("outstanding req", {31'd0, req}, 32'h0);
      rst = 1'b1;
      #1;
      check_ifid("async reset", 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, NOP);
      @(posedge clk);
      #1;
      rst = 1'b0; gnt = 1'b0; rvalid = 1'b1; rdata = 32'hBAD0_BAD0;
      repeat (3) @(posedge clk);
      #1;
      check_ifid("stale rvalid", 1'b1, 32'h0, 1'b0, 32'h0, 32'h0, NOP);
      gnt = 1'b1; rvalid = 1'b0;
      @(posedge clk);
      #1;
      gnt = 1'b0; rvalid = 1'b1; rdata = 32'h1234_5678;
      @(posedge clk);
      #1;
      check_ifid("post reset fetch", 1'b1, 32'h4, 1'b1, 32'h0, 32'h4, 32'h1234_5678);
      rvalid = 1'b0;

`ifdef FETCH_MISALIGN_CHECK_EN
      redirect = 1'b1; target = 32'h102;
      @(posedge clk);
      #1;
      redirect = 1'b0; target = 32'h0;
      check("misaligned pulse", {31'd0, mis}, 32'h1);
      check("aligned addr", addr, 32'h100);
      @(posedge clk);
      #1;
      check("misaligned drop", {31'd0, mis}, 32'h0);
      check("aligned addr hold", addr, 32'h100);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
